serial_subtractor_ctrl: RTL and testbench

Bit-serial multi-bit subtractor controller. It accepts a WIDTH-bit minuend and subtrahend on a start pulse and computes a - b - bin. It sequences a single 1-bit full-subtractor cell LSB-first, one bit per clock, and returns the difference and final borrow with a done pulse. It trades area for latency and is reused by later arithmetic blocks that share one subtractor cell.

---
 rtl/serial_sub_pkg.sv | 10 +
 rtl/serial_subtractor_ctrl_cell.sv | 23 ++
 rtl/serial_subtractor_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor controller.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor_ctrl_cell.sv
// One-bit full subtractor built from two half-subtractor stages and an OR.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hd1;
    logic hb1;
    logic hb2;

    // Stage 1 forms a - b, stage 2 subtracts the incoming borrow.
    always_comb begin
        hd1  = a ^ b;
        hb1  = ~a & b;
        d    = hd1 ^ bin;
        hb2  = ~hd1 & bin;
        bout = hb1 | hb2;
    end

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: computes a - b - bin LSB-first through one
// shared full-subtractor cell, one bit per clock, with a one-cycle done pulse.
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] d_sh_q, d_sh_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             dbit;
    logic             nb;

    full_subtractor_cell u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (br_q),
        .d    (dbit),
        .bout (nb)
    );

    // Next-state logic: FSM sequencing, operand shifting and result capture.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        d_sh_d  = d_sh_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    d_sh_d  = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                d_sh_d = {dbit, d_sh_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = nb;
                // Counter holds at its last value instead of wrapping.
                if (cnt_q == CNT_LAST) begin
                    d_d     = {dbit, d_sh_q[WIDTH-1:1]};
                    bout_d  = nb;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            d_sh_q  <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            d_sh_q  <= d_sh_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed scoreboard bench for serial_subtractor_ctrl (WIDTH=8).
module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         bin_i;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .bin   (bin_i),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        logic [W:0] full;
        exp_t e;
        full   = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        e.d    = full[W-1:0];
        e.bout = full[W];
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_d", 32'(d), 32'(e.d));
                check("sb_bout", 32'(bout), 32'(e.bout));
            end
        end
    end

    // One operation; optionally pulse a second start two edges after acceptance.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                          input bit intrude, input string tag);
        int n;
        int busy_cycles;
        @(negedge clk);
        a_i = x; b_i = y; bin_i = bi; start = 1'b1;
        sb.push_back(model(x, y, bi));
        @(posedge clk); #1;
        start = 1'b0;
        a_i = W'($urandom); b_i = W'($urandom); bin_i = 1'($urandom);
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        n = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && n < 20) begin
            busy_cycles += int'(busy === 1'b1);
            if (intrude && n == 1) begin
                start = 1'b1; a_i = 8'd1; b_i = 8'd2; bin_i = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(W));
        while (busy === 1'b1 && busy_cycles < 30) begin
            busy_cycles++;
            @(posedge clk); #1;
        end
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(W + 1));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a_i = '0; b_i = '0; bin_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'd100, 8'd37, 1'b0, 1'b0, "t1");
        run_op(8'd5, 8'd9, 1'b0, 1'b0, "t2");
        run_op(8'd0, 8'd0, 1'b1, 1'b0, "t3a");
        run_op(8'hFF, 8'hFF, 1'b0, 1'b0, "t3b");
        run_op(8'd50, 8'd20, 1'b0, 1'b1, "t4");
        repeat (12) @(posedge clk);

        // Abort mid-operation with reset after cnt reaches 3.
        @(negedge clk);
        a_i = 8'd77; b_i = 8'd11; bin_i = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t5_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_d", 32'(d), 32'd0);
        check("t5_rst_bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(posedge clk);
        run_op(8'd10, 8'd3, 1'b0, 1'b0, "t5");

        // start held high: back-to-back operations every WIDTH+2 edges.
        @(negedge clk);
        a_i = 8'd200; b_i = 8'd100; bin_i = 1'b0; start = 1'b1;
        repeat (3) sb.push_back(model(8'd200, 8'd100, 1'b0));
        @(posedge clk); #1;
        check("t6_held_prior_d", 32'(d), 32'd7);
        for (int n = 1; n <= 29; n++) begin
            @(posedge clk); #1;
            check($sformatf("t6_done_e%0d", n), 32'(done), 32'(n % 10 == 8));
            if (n == 10) begin
                check("t6_reaccept_busy", 32'(busy), 32'd1);
                check("t6_reaccept_d", 32'(d), 32'd100);
            end
            if (n == 28) start = 1'b0;
        end
        repeat (12) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("final_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
